// File: rtl/commutation_sequencer_if.sv
// Bundles the run controls, hall inputs and gate/status outputs of the commutation sequencer.
// Latency: none, signal grouping only.
// Backpressure: none; all signals are levels or single-cycle pulses.
// Ports (slave side = sequencer):
//   enable, direction, duty[PWM_BITS], hall1/2/3        -> into the sequencer
//   PHASES[5:0], sector[2:0], commutate, hall_fault, stall <- from the sequencer
interface commutation_sequencer_if #(
    parameter int PWM_BITS = 10
);
    logic                enable;
    logic                direction;
    logic [PWM_BITS-1:0] duty;
    logic                hall1;
    logic                hall2;
    logic                hall3;
    logic [5:0]          PHASES;
    logic [2:0]          sector;
    logic                commutate;
    logic                hall_fault;
    logic                stall;

    modport master (
        output enable, direction, duty, hall1, hall2, hall3,
        input  PHASES, sector, commutate, hall_fault, stall
    );

    modport slave (
        input  enable, direction, duty, hall1, hall2, hall3,
        output PHASES, sector, commutate, hall_fault, stall
    );
endinterface

// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation: filtered halls -> sector -> dead-time -> PWM'd high side / solid low side.
// Latency: hall change accepted at edge t -> gates off at t+1, new pattern at t+1+DEADTIME.
// Backpressure: none; faults latch in FAULT until enable is dropped.
// Ports: CLK, reset (async, active-high), bus (slave modport of commutation_sequencer_if):
//   in  enable, direction, duty, hall1/2/3; out PHASES, sector, commutate, hall_fault, stall
module commutation_sequencer #(
    parameter int PWM_BITS     = 10,
    parameter int DEADTIME     = 16,
    parameter int HALL_FILTER  = 4,
    parameter int STALL_CYCLES = 1600000
) (
    input  logic                    CLK,
    input  logic                    reset,
    commutation_sequencer_if.slave  bus
);
    localparam int DT_W = $clog2(DEADTIME + 1);
    localparam int HF_W = $clog2(HALL_FILTER + 1);
    localparam int ST_W = $clog2(STALL_CYCLES + 1);

    localparam logic [DT_W-1:0] DT_LAST    = DT_W'(DEADTIME - 1);
    localparam logic [HF_W-1:0] HF_FULL    = HF_W'(HALL_FILTER);
    localparam logic [HF_W-1:0] HF_LAST    = HF_W'(HALL_FILTER - 1);
    localparam logic [ST_W-1:0] STALL_LAST = ST_W'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DEADTIME, ST_DRIVE, ST_FAULT} state_t;

    // {valid, sector}; 000 and 111 are not produced by a healthy sensor set.
    function automatic logic [3:0] hall_to_sector(input logic [2:0] v);
        case (v)
            3'b001:  return {1'b1, 3'd0};
            3'b011:  return {1'b1, 3'd1};
            3'b010:  return {1'b1, 3'd2};
            3'b110:  return {1'b1, 3'd3};
            3'b100:  return {1'b1, 3'd4};
            3'b101:  return {1'b1, 3'd5};
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_adjacent(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] up;
        logic [2:0] dn;
        up = (a == 3'd5) ? 3'd0 : a + 3'd1;
        dn = (a == 3'd0) ? 3'd5 : a - 3'd1;
        return (b == up) || (b == dn);
    endfunction

    // Returns {lo[2:0], hi[2:0]}; reverse rotation drives the opposite sector.
    function automatic logic [5:0] drive_pattern(input logic [2:0] s, input logic rev,
                                                 input logic hi_on);
        logic [2:0] idx;
        logic [2:0] hi;
        logic [2:0] lo;
        idx = rev ? ((s >= 3'd3) ? s - 3'd3 : s + 3'd3) : s;
        case (idx)
            3'd0:    begin hi = 3'b001; lo = 3'b010; end
            3'd1:    begin hi = 3'b001; lo = 3'b100; end
            3'd2:    begin hi = 3'b010; lo = 3'b100; end
            3'd3:    begin hi = 3'b010; lo = 3'b001; end
            3'd4:    begin hi = 3'b100; lo = 3'b001; end
            3'd5:    begin hi = 3'b100; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        return {lo, hi & {3{hi_on}}};
    endfunction

    // ---------------- hall synchroniser and filter ----------------
    logic [2:0]      sync1, sync2, filt_prev, h;
    logic [HF_W-1:0] filt_cnt;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1     <= 3'b000;
            sync2     <= 3'b000;
            filt_prev <= 3'b000;
            filt_cnt  <= '0;
            h         <= 3'b000;
        end else begin
            sync1 <= {bus.hall3, bus.hall2, bus.hall1};
            sync2 <= sync1;
            if (sync2 != filt_prev) begin
                filt_prev <= sync2;
                filt_cnt  <= HF_W'(1);
                if (HALL_FILTER == 1)
                    h <= sync2;
            end else if (filt_cnt < HF_FULL) begin
                filt_cnt <= filt_cnt + 1'b1;
                if (filt_cnt == HF_LAST)
                    h <= sync2;
            end
        end
    end

    logic [3:0] h_map;
    logic       h_valid;
    logic [2:0] h_sec;
    assign h_map   = hall_to_sector(h);
    assign h_valid = h_map[3];
    assign h_sec   = h_map[2:0];

    // ---------------- PWM ----------------
    logic [PWM_BITS-1:0] pwm_cnt, duty_q;
    logic                hi_on;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1)
                duty_q <= bus.duty;   // duty only takes effect from the next period
        end
    end

    assign hi_on = (pwm_cnt < duty_q);

    // ---------------- sequencing FSM ----------------
    state_t          state;
    logic [2:0]      sector_q, target;
    logic [DT_W-1:0] dt_cnt;
    logic [ST_W-1:0] stall_cnt;
    logic [5:0]      phases_q;
    logic            commutate_q, hall_fault_q, stall_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sector_q     <= 3'd0;
            target       <= 3'd0;
            dt_cnt       <= '0;
            stall_cnt    <= '0;
            phases_q     <= 6'b0;
            commutate_q  <= 1'b0;
            hall_fault_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            commutate_q <= 1'b0;
            if (!bus.enable) begin
                state        <= ST_IDLE;
                phases_q     <= 6'b0;
                dt_cnt       <= '0;
                stall_cnt    <= '0;
                hall_fault_q <= 1'b0;
                stall_q      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        phases_q  <= 6'b0;
                        stall_cnt <= '0;
                        if (h_valid) begin
                            state  <= ST_DEADTIME;
                            target <= h_sec;
                            dt_cnt <= '0;
                        end else begin
                            state        <= ST_FAULT;
                            hall_fault_q <= 1'b1;
                        end
                    end
                    ST_DEADTIME: begin
                        phases_q  <= 6'b0;
                        stall_cnt <= '0;
                        if (!h_valid) begin
                            state        <= ST_FAULT;
                            hall_fault_q <= 1'b1;
                        end else if (h_sec != target) begin
                            // Rotor moved again before we drove: aim at the newest sector.
                            target <= h_sec;
                            dt_cnt <= '0;
                        end else if (dt_cnt == DT_LAST) begin
                            state       <= ST_DRIVE;
                            sector_q    <= target;
                            phases_q    <= drive_pattern(target, bus.direction, hi_on);
                            commutate_q <= 1'b1;
                        end else begin
                            dt_cnt <= dt_cnt + 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (!h_valid) begin
                            state        <= ST_FAULT;
                            phases_q     <= 6'b0;
                            hall_fault_q <= 1'b1;
                        end else if (h_sec != sector_q) begin
                            phases_q <= 6'b0;
                            if (is_adjacent(sector_q, h_sec)) begin
                                state  <= ST_DEADTIME;
                                target <= h_sec;
                                dt_cnt <= '0;
                            end else begin
                                state        <= ST_FAULT;
                                hall_fault_q <= 1'b1;
                            end
                        end else if (duty_q == '0) begin
                            // No torque requested, so a stationary rotor is not a stall.
                            stall_cnt <= '0;
                            phases_q  <= drive_pattern(sector_q, bus.direction, hi_on);
                        end else if (stall_cnt >= STALL_LAST) begin
                            state    <= ST_FAULT;
                            phases_q <= 6'b0;
                            stall_q  <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                            phases_q  <= drive_pattern(sector_q, bus.direction, hi_on);
                        end
                    end
                    default: begin
                        phases_q <= 6'b0;
                    end
                endcase
            end
        end
    end

    assign bus.PHASES     = phases_q;
    assign bus.sector     = sector_q;
    assign bus.commutate  = commutate_q;
    assign bus.hall_fault = hall_fault_q;
    assign bus.stall      = stall_q;
endmodule

// File: tb/tb_commutation_sequencer.sv
module tb_commutation_sequencer;
    localparam int PWM_BITS     = 10;
    localparam int DEADTIME     = 16;
    localparam int HALL_FILTER  = 4;
    localparam int STALL_CYCLES = 4000;
    // Hall written at the negedge of cycle n: two sync flops, HALL_FILTER samples, one FSM edge.
    localparam int HALL_REACT   = 3 + HALL_FILTER;

    logic CLK = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    commutation_sequencer_if #(.PWM_BITS(PWM_BITS)) bus ();

    commutation_sequencer #(
        .PWM_BITS(PWM_BITS), .DEADTIME(DEADTIME),
        .HALL_FILTER(HALL_FILTER), .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef enum int {EV_COMM, EV_HFAULT, EV_STALL} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         sec;
        logic [5:0] hi_m;
        logic [5:0] lo_m;
        int         at;
    } ev_t;

    ev_t  exp_q[$];
    int   hall_of_sec[6] = '{1, 3, 2, 6, 4, 5};
    int   cur_sec = 0;
    bit   dir_b = 1'b0;
    int   last_comm = 0;
    logic hf_prev = 1'b0;
    logic st_prev = 1'b0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Six-step table by arithmetic: high phase A,A,B,B,C,C; low phase B,C,C,A,A,B.
    function automatic void ref_pattern(input int s, input bit rev,
                                        output logic [5:0] hi, output logic [5:0] lo);
        int idx;
        idx = rev ? (s + 3) % 6 : s;
        hi  = 6'(1 << (idx / 2));
        lo  = 6'(1 << (3 + ((idx + 1) / 2 + 1) % 3));
    endfunction

    task automatic push(input ev_kind_t k, input int s, input int at);
        ev_t e;
        e.kind = k;
        e.sec  = s;
        ref_pattern(s, dir_b, e.hi_m, e.lo_m);
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic take_event(input ev_kind_t k);
        ev_t e;
        chk("event_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("event_kind", int'(k), int'(e.kind));
        case (k)
            EV_COMM: begin
                chk("comm_sector", bus.sector, e.sec);
                chk("comm_lo_gate", bus.PHASES & e.lo_m, e.lo_m);
                chk("comm_stray_gate", bus.PHASES & ~(e.hi_m | e.lo_m), 0);
                chk("comm_cycle", cyc, e.at);
                last_comm = cyc;
            end
            EV_HFAULT: begin
                chk("hfault_phases", bus.PHASES, 0);
                chk("hfault_cycle", cyc, e.at);
            end
            default: begin
                chk("stall_phases", bus.PHASES, 0);
                chk("stall_cycle", cyc, last_comm + STALL_CYCLES);
            end
        endcase
    endtask

    // Monitor: gate invariant every cycle, scoreboard pop on every observable event.
    always @(negedge CLK) begin
        logic inv_ok;
        if (!reset) begin
            inv_ok = 1'b1;
            for (int i = 0; i < 3; i++)
                if (bus.PHASES[i] && bus.PHASES[i+3]) inv_ok = 1'b0;
            if ($countones(bus.PHASES[2:0]) > 1 || $countones(bus.PHASES[5:3]) > 1)
                inv_ok = 1'b0;
            chk("gate_invariant", inv_ok, 1);
            if (bus.commutate) take_event(EV_COMM);
            if (bus.hall_fault && !hf_prev) take_event(EV_HFAULT);
            if (bus.stall && !st_prev) take_event(EV_STALL);
            hf_prev = bus.hall_fault;
            st_prev = bus.stall;
        end else begin
            hf_prev = 1'b0;
            st_prev = 1'b0;
        end
    end

    task automatic drive_hall(input int v);
        bus.hall1 = v[0];
        bus.hall2 = v[1];
        bus.hall3 = v[2];
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic settle_hall(input int s);
        @(negedge CLK);
        drive_hall(hall_of_sec[s]);
        cur_sec = s;
        repeat (HALL_FILTER + 6) @(negedge CLK);
    endtask

    task automatic enable_run(input bit expect_stall);
        int n;
        @(negedge CLK);
        n = cyc;
        bus.enable = 1'b1;
        push(EV_COMM, cur_sec, n + 1 + DEADTIME);
        if (expect_stall) push(EV_STALL, cur_sec, -1);
        drain(expect_stall ? STALL_CYCLES + 200 : 100);
    endtask

    task automatic step_to(input int s);
        int n;
        @(negedge CLK);
        n = cyc;
        drive_hall(hall_of_sec[s]);
        push(EV_COMM, s, n + HALL_REACT + DEADTIME);
        cur_sec = s;
        while (cyc < n + HALL_REACT) @(negedge CLK);
        for (int i = 0; i < DEADTIME; i++) begin
            chk("deadtime_off", bus.PHASES, 0);
            @(negedge CLK);
        end
        drain(50);
    endtask

    task automatic fault_hall(input int v);
        int n;
        @(negedge CLK);
        n = cyc;
        drive_hall(v);
        push(EV_HFAULT, cur_sec, n + HALL_REACT);
        drain(100);
        repeat (5) @(negedge CLK);
        chk("fault_phases_held", bus.PHASES, 0);
        chk("fault_flag_held", bus.hall_fault, 1);
    endtask

    task automatic go_idle();
        @(negedge CLK);
        bus.enable = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_phases", bus.PHASES, 0);
        chk("idle_hall_fault", bus.hall_fault, 0);
        chk("idle_stall", bus.stall, 0);
    endtask

    task automatic wait_a_hi(input bit lvl, input int budget);
        int i;
        i = 0;
        while (bus.PHASES[0] != lvl && i < budget) begin
            @(negedge CLK);
            i++;
        end
        chk("pwm_edge_seen", bus.PHASES[0], lvl);
    endtask

    task automatic measure_run(input int switch_at, input int new_duty, output int len);
        len = 0;
        while (bus.PHASES[0] && len < 2000) begin
            len++;
            if (len == switch_at) bus.duty = PWM_BITS'(new_duty);
            @(negedge CLK);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt, lo_cnt, d1, d2, run1, run2, g;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.direction = 1'b0;
        bus.duty = PWM_BITS'(512);
        drive_hall(hall_of_sec[0]);
        repeat (3) @(negedge CLK);
        chk("reset_phases", bus.PHASES, 0);
        chk("reset_sector", bus.sector, 0);
        chk("reset_commutate", bus.commutate, 0);
        chk("reset_hall_fault", bus.hall_fault, 0);
        chk("reset_stall", bus.stall, 0);
        reset = 1'b0;
        repeat (1100) @(negedge CLK);
        chk("idle_before_enable", bus.PHASES, 0);

        // Forward start at sector 0, 50% PWM on A_hi with B_lo held.
        enable_run(1'b0);
        hi_cnt = 0;
        lo_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge CLK);
            hi_cnt += int'(bus.PHASES[0]);
            lo_cnt += int'(bus.PHASES[4]);
        end
        chk("pwm50_a_hi_count", hi_cnt, 512);
        chk("b_lo_held_count", lo_cnt, 1024);

        // Forward steps, then a random adjacent walk with random duty.
        step_to(1);
        step_to(2);
        for (int k = 0; k < 6; k++) begin
            bus.duty = PWM_BITS'($urandom_range(1, 1023));
            step_to((cur_sec + ($urandom_range(0, 1) ? 1 : 5)) % 6);
        end

        // Reverse rotation from sector 0 drives the B/A pattern.
        go_idle();
        bus.direction = 1'b1;
        dir_b = 1'b1;
        settle_hall(0);
        enable_run(1'b0);
        for (int k = 0; k < 4; k++)
            step_to((cur_sec + ($urandom_range(0, 1) ? 1 : 5)) % 6);
        go_idle();
        bus.direction = 1'b0;
        dir_b = 1'b0;

        // Illegal jump, then invalid vector; FAULT holds until enable drops.
        settle_hall(0);
        enable_run(1'b0);
        fault_hall(hall_of_sec[(cur_sec + $urandom_range(2, 4)) % 6]);
        go_idle();
        settle_hall(0);
        enable_run(1'b0);
        fault_hall(7);
        drive_hall(hall_of_sec[0]);
        repeat (12) @(negedge CLK);
        chk("fault_sticky_after_valid_hall", bus.hall_fault, 1);
        go_idle();

        // Stall with torque requested, none with duty 0.
        bus.duty = PWM_BITS'(100);
        repeat (1100) @(negedge CLK);
        enable_run(1'b1);
        go_idle();
        bus.duty = '0;
        repeat (1100) @(negedge CLK);
        enable_run(1'b0);
        hi_cnt = 0;
        repeat (STALL_CYCLES + 500) begin
            @(negedge CLK);
            hi_cnt += int'(|bus.PHASES[2:0]);
        end
        chk("no_stall_duty0", bus.stall, 0);
        chk("duty0_hi_never", hi_cnt, 0);

        // Hall glitch shorter than the filter is ignored.
        g = $urandom_range(1, HALL_FILTER - 1);
        @(negedge CLK);
        drive_hall(hall_of_sec[(cur_sec + 1) % 6]);
        repeat (g) @(negedge CLK);
        drive_hall(hall_of_sec[cur_sec]);
        repeat (40) @(negedge CLK);
        chk("glitch_sector", bus.sector, cur_sec);
        chk("glitch_b_lo", bus.PHASES[4], 1);

        // Duty change mid-pulse only takes effect after the wrap.
        go_idle();
        d1 = $urandom_range(100, 900);
        d2 = $urandom_range(100, 900);
        bus.duty = PWM_BITS'(d1);
        repeat (1100) @(negedge CLK);
        enable_run(1'b0);
        wait_a_hi(1'b0, 1100);
        wait_a_hi(1'b1, 1100);
        measure_run(d1 / 2, d2, run1);
        chk("pwm_run_before_wrap", run1, d1);
        wait_a_hi(1'b1, 1100);
        measure_run(0, d2, run2);
        chk("pwm_run_after_wrap", run2, d2);

        // Asynchronous reset in the middle of DRIVE.
        step_to(1);
        @(negedge CLK);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_phases", bus.PHASES, 0);
        chk("async_reset_sector", bus.sector, 0);
        chk("async_reset_commutate", bus.commutate, 0);
        chk("async_reset_hall_fault", bus.hall_fault, 0);
        chk("async_reset_stall", bus.stall, 0);
        bus.enable = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        chk("post_reset_idle_phases", bus.PHASES, 0);

        chk("queue_empty_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
